// File: rtl/pwm_duty.sv
// pwm_duty: button-controlled PWM with period-aligned duty updates
module pwm_duty #(
    parameter int PERIOD     = 10,
    parameter int DUTY_RESET = 5,
    parameter int STEP       = 1
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int STEP_C = (STEP > PERIOD) ? PERIOD : STEP;
    localparam logic [3:0] LAST = 4'(PERIOD - 1);
    localparam logic [3:0] MAXD = 4'(PERIOD);
    localparam logic [3:0] RSTD = 4'(DUTY_RESET);
    localparam logic [3:0] STP  = 4'(STEP_C);
    logic clk, rst, inc_btn, dec_btn;
    logic unused_low;
    logic [3:0] cnt = '0;
    logic inc_s1 = 1'b0, inc_s2 = 1'b0, inc_prev = 1'b0;
    logic dec_s1 = 1'b0, dec_s2 = 1'b0, dec_prev = 1'b0;
    logic [3:0] duty_pend = RSTD;
    logic [3:0] duty_active = RSTD;
    logic inc_press, dec_press;
    logic [4:0] up_sum;
    logic [3:0] duty_up, duty_dn, pend_next;
    assign clk        = io_in[5];
    assign rst        = io_in[4];
    assign inc_btn    = io_in[6];
    assign dec_btn    = io_in[7];
    assign unused_low = ^io_in[3:0];
    assign inc_press  = inc_s2 & ~inc_prev;
    assign dec_press  = dec_s2 & ~dec_prev;
    assign up_sum     = {1'b0, duty_pend} + {1'b0, STP};
    assign duty_up    = (up_sum > {1'b0, MAXD}) ? MAXD : up_sum[3:0];
    assign duty_dn    = (duty_pend < STP) ? 4'd0 : duty_pend - STP;
    // Simultaneous presses cancel; otherwise step with saturation.
    always_comb begin
        pend_next = duty_pend;
        if (inc_press ^ dec_press)
            pend_next = inc_press ? duty_up : duty_dn;
    end
    // Two-stage synchronizers plus one history flop per button for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            {inc_s1, inc_s2, inc_prev} <= 3'b000;
            {dec_s1, dec_s2, dec_prev} <= 3'b000;
        end else begin
            {inc_s1, inc_s2, inc_prev} <= {inc_btn, inc_s1, inc_s2};
            {dec_s1, dec_s2, dec_prev} <= {dec_btn, dec_s1, dec_s2};
        end
    end
    // Free-running period counter, wrapping at the end of each period.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (cnt == LAST) ? 4'd0 : cnt + 4'd1;
    end
    // Pending duty follows presses; applied duty latches it only at the period boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_pend   <= RSTD;
            duty_active <= RSTD;
        end else begin
            duty_pend <= pend_next;
            if (cnt == LAST)
                duty_active <= pend_next;
        end
    end
    assign io_out = {duty_active, duty_active == MAXD, cnt < duty_active,
                     duty_active == 4'd0, cnt == 4'd0};
endmodule

// File: tb/tb_pwm_duty.sv
// tb_pwm_duty: randomized scoreboard bench for pwm_duty against a cycle-level reference model
module tb_pwm_duty;
    localparam int PERIOD = 10;
    localparam int DUTY_RESET = 5;
    localparam int STEP = 1;
    logic clk = 1'b0;
    logic rst = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [3:0] junk = '0;
    logic [7:0] io_in, io_out;
    logic [7:0] exp_q[$];
    int checks = 0, errors = 0, cyc = 0;
    int m_phase = 0, m_pend = DUTY_RESET, m_active = DUTY_RESET;
    bit hi[$] = '{0, 0, 0};
    bit hd[$] = '{0, 0, 0};

    assign io_in = {dec, inc, clk, rst, junk};

    pwm_duty #(.PERIOD(PERIOD), .DUTY_RESET(DUTY_RESET), .STEP(STEP)) dut (
        .io_in(io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    // Reference: a press is a button sample seen high two edges ago after being low three edges ago.
    task automatic model_step(input bit i, input bit d, input bit r);
        bit pi, pd;
        if (r) begin
            m_phase = 0;
            m_pend = DUTY_RESET;
            m_active = DUTY_RESET;
            hi = '{0, 0, 0};
            hd = '{0, 0, 0};
        end else begin
            pi = hi[1] && !hi[0];
            pd = hd[1] && !hd[0];
            if (pi && !pd) m_pend = (m_pend + STEP > PERIOD) ? PERIOD : m_pend + STEP;
            if (pd && !pi) m_pend = (m_pend < STEP) ? 0 : m_pend - STEP;
            if (m_phase == PERIOD - 1) m_active = m_pend;
            m_phase = (m_phase + 1) % PERIOD;
            hi.push_back(i);
            void'(hi.pop_front());
            hd.push_back(d);
            void'(hd.pop_front());
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] a;
        a = 4'(m_active);
        return {a, m_active == PERIOD, m_phase < m_active, m_active == 0, m_phase == 0};
    endfunction

    // Hold the given inputs across one clock edge, then record what the outputs must become.
    task automatic tick(input bit i, input bit d, input bit r);
        inc = i;
        dec = d;
        rst = r;
        junk = 4'($urandom);
        @(posedge clk);
        #1;
        model_step(i, d, r);
        exp_q.push_back(model_out());
    endtask

    task automatic hold(input bit i, input bit d, input int n);
        for (int k = 0; k < n; k++) tick(i, d, 1'b0);
    endtask

    task automatic to_phase(input int p);
        for (int k = 0; k < PERIOD && m_phase != p; k++) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a fresh output word; compare it to the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (io_out !== e) begin
                errors++;
                $display("FAIL io_out cycle %0d: got %b expected %b", cyc, io_out, e);
            end
            cyc++;
        end
    end

    initial begin
        hold(1'b0, 1'b0, 3);
        tick(1'b0, 1'b0, 1'b1);
        hold(1'b0, 1'b0, 20);
        hold(1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 20);
        for (int k = 0; k < 7; k++) begin
            hold(1'b1, 1'b0, 2);
            hold(1'b0, 1'b0, 2);
        end
        hold(1'b0, 1'b0, 12);
        for (int k = 0; k < 12; k++) begin
            hold(1'b0, 1'b1, 2);
            hold(1'b0, 1'b0, 2);
        end
        hold(1'b0, 1'b0, 12);
        tick(1'b0, 1'b0, 1'b1);
        hold(1'b1, 1'b0, 50);
        hold(1'b0, 1'b0, 12);
        hold(1'b1, 1'b1, 3);
        hold(1'b0, 1'b0, 12);
        to_phase(2);
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 20);
        to_phase(4);
        tick(1'b0, 1'b0, 1'b1);
        hold(1'b0, 1'b0, 12);
        for (int k = 0; k < 200; k++) begin
            int n;
            bit r;
            n = $urandom_range(1, 6);
            r = ($urandom_range(0, 39) == 0);
            if (r) tick(1'b0, 1'b0, 1'b1);
            else hold(1'($urandom), 1'($urandom), n);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
